addr_decoder_ws: RTL and testbench

Parametrised, registered chip-enable decoder with request/acknowledge handshake and programmable wait states. It decodes an `ADDR_W`-bit address into one of `N_CE` one-hot chip enables and holds the enable for a fixed number of cycles. It then acknowledges completion or flags an unmapped address. It sits between the bus master and the chip-select lines of the memory-mapped peripherals.

---
 rtl/addr_decoder_ws_pkg.sv | 16 +
 rtl/addr_decoder_ws_if.sv | 15 +
 rtl/addr_decoder_ws_ce_onehot_dec.sv | 24 ++
 rtl/addr_decoder_ws.sv | 108 ++++++++++
 tb/tb_addr_decoder_ws.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/addr_decoder_ws_pkg.sv
// Shared types and constants for the wait-state chip-enable decoder.
package addr_decoder_ws_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_FAULT  = 2'd2
    } state_e;

    localparam int unsigned WAIT_CYCLES_MAX = 255;

    function automatic int unsigned cnt_width(input int unsigned wait_cycles);
        return (wait_cycles == 0) ? 1 : $clog2(wait_cycles + 1);
    endfunction

endpackage

// File: rtl/addr_decoder_ws_if.sv
// Request/acknowledge bus between a master and the chip-enable decoder.
interface addr_decoder_ws_if #(
    parameter int ADDR_W = 8,
    parameter int N_CE   = 2
);
    logic              REQ;
    logic [ADDR_W-1:0] ADDRESS;
    logic [N_CE-1:0]   CE;
    logic              BUSY;
    logic              ACK;
    logic              ERR;

    modport master (output REQ, ADDRESS, input CE, BUSY, ACK, ERR);
    modport slave  (input REQ, ADDRESS, output CE, BUSY, ACK, ERR);
endinterface

// File: rtl/addr_decoder_ws_ce_onehot_dec.sv
// Combinational address-to-one-hot decode; addresses at or above N_CE are unmapped.
module ce_onehot_dec
    import addr_decoder_ws_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int N_CE   = 2
) (
    input  logic [ADDR_W-1:0] address,
    output logic [N_CE-1:0]   ce_onehot,
    output logic              mapped
);

    always_comb begin
        ce_onehot = '0;
        mapped    = 1'b0;
        for (int i = 0; i < N_CE; i++) begin
            if (address == ADDR_W'(i)) begin
                ce_onehot[i] = 1'b1;
                mapped       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/addr_decoder_ws.sv
// Registered chip-enable decoder with programmable wait states and ACK/ERR completion.
//   state     | meaning
//   ST_IDLE   | waiting for REQ; all outputs low
//   ST_ACCESS | CE held while the wait counter runs down; ACK on the last cycle
//   ST_FAULT  | single cycle with ERR for an unmapped address
module addr_decoder_ws
    import addr_decoder_ws_pkg::*;
#(
    parameter int          ADDR_W      = 8,
    parameter int          N_CE        = 2,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic              CLK,
    input  logic              RST,
    addr_decoder_ws_if.slave  bus
);

    // Out-of-range wait counts saturate rather than wrap the counter.
    localparam int unsigned     WAIT_EFF = (WAIT_CYCLES > WAIT_CYCLES_MAX) ? WAIT_CYCLES_MAX
                                                                           : WAIT_CYCLES;
    localparam int              CNT_W    = cnt_width(WAIT_EFF);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_EFF);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [N_CE-1:0]  ce_q,    ce_d;
    logic             busy_q,  busy_d;
    logic             ack_q,   ack_d;
    logic             err_q,   err_d;

    logic [N_CE-1:0]  dec_ce;
    logic             dec_mapped;

    ce_onehot_dec #(
        .ADDR_W (ADDR_W),
        .N_CE   (N_CE)
    ) u_dec (
        .address   (bus.ADDRESS),
        .ce_onehot (dec_ce),
        .mapped    (dec_mapped)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ce_d    = ce_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.REQ) begin
                    if (dec_mapped) begin
                        state_d = ST_ACCESS;
                        cnt_d   = CNT_LOAD;
                        ce_d    = dec_ce;
                    end else begin
                        state_d = ST_FAULT;
                        ce_d    = '0;
                    end
                end
            end
            ST_ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = ST_IDLE;
                    ce_d    = '0;
                end
            end
            ST_FAULT: begin
                state_d = ST_IDLE;
                ce_d    = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                ce_d    = '0;
            end
        endcase

        // Flags are derived from the next state so they line up with CE after the edge.
        busy_d = (state_d != ST_IDLE);
        ack_d  = (state_d == ST_ACCESS) && (cnt_d == '0);
        err_d  = (state_d == ST_FAULT);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ce_q    <= '0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ce_q    <= ce_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign bus.CE   = ce_q;
    assign bus.BUSY = busy_q;
    assign bus.ACK  = ack_q;
    assign bus.ERR  = err_q;

endmodule

// File: tb/tb_addr_decoder_ws.sv
// Scoreboard bench for addr_decoder_ws across three parameter sets sharing one clock and reset.
module tb_addr_decoder_ws;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    addr_decoder_ws_if #(.ADDR_W(8), .N_CE(2)) if_a ();
    addr_decoder_ws_if #(.ADDR_W(8), .N_CE(4)) if_b ();
    addr_decoder_ws_if #(.ADDR_W(8), .N_CE(2)) if_c ();

    addr_decoder_ws #(.ADDR_W(8), .N_CE(2), .WAIT_CYCLES(0)) u_a (.CLK(clk), .RST(rst), .bus(if_a));
    addr_decoder_ws #(.ADDR_W(8), .N_CE(4), .WAIT_CYCLES(3)) u_b (.CLK(clk), .RST(rst), .bus(if_b));
    addr_decoder_ws #(.ADDR_W(8), .N_CE(2), .WAIT_CYCLES(5)) u_c (.CLK(clk), .RST(rst), .bus(if_c));

    typedef struct {
        logic       is_err;
        logic [3:0] ce;
        int         len;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    int   n_cmp = 0;
    int   n_bad = 0;
    logic mon_en = 1'b0;

    logic [3:0] ce_s   [3];
    logic       busy_s [3];
    logic       ack_s  [3];
    logic       err_s  [3];

    assign ce_s[0] = {2'b00, if_a.CE};
    assign ce_s[1] = if_b.CE;
    assign ce_s[2] = {2'b00, if_c.CE};
    assign busy_s[0] = if_a.BUSY;
    assign busy_s[1] = if_b.BUSY;
    assign busy_s[2] = if_c.BUSY;
    assign ack_s[0] = if_a.ACK;
    assign ack_s[1] = if_b.ACK;
    assign ack_s[2] = if_c.ACK;
    assign err_s[0] = if_a.ERR;
    assign err_s[1] = if_b.ERR;
    assign err_s[2] = if_c.ERR;

    function automatic exp_t mk(input logic is_err, input logic [3:0] ce, input int len);
        exp_t e;
        e.is_err = is_err;
        e.ce     = ce;
        e.len    = len;
        return e;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h at %0t", name, idx, act, exp, $time);
        end
    endtask

    task automatic drive(input int idx, input logic req, input logic [7:0] addr);
        case (idx)
            0: begin if_a.REQ = req; if_a.ADDRESS = addr; end
            1: begin if_b.REQ = req; if_b.ADDRESS = addr; end
            default: begin if_c.REQ = req; if_c.ADDRESS = addr; end
        endcase
    endtask

    task automatic push(input int idx, input exp_t e);
        case (idx)
            0: q_a.push_back(e);
            1: q_b.push_back(e);
            default: q_c.push_back(e);
        endcase
    endtask

    task automatic pop(input int idx, output exp_t e);
        case (idx)
            0: e = q_a.pop_front();
            1: e = q_b.pop_front();
            default: e = q_c.pop_front();
        endcase
    endtask

    function automatic int qsize(input int idx);
        case (idx)
            0: return q_a.size();
            1: return q_b.size();
            default: return q_c.size();
        endcase
    endfunction

    function automatic logic [3:0] front_ce(input int idx);
        case (idx)
            0: return q_a[0].ce;
            1: return q_b[0].ce;
            default: return q_c[0].ce;
        endcase
    endfunction

    // Called at #1 after an edge; returns in the cycle carrying ACK or ERR.
    task automatic wait_resp(input int idx);
        int n;
        n = 0;
        while (!(ack_s[idx] || err_s[idx]) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("resp_in_time", idx, 32'(n < 300), 32'd1);
    endtask

    task automatic run_access(input int idx, input logic [7:0] addr, input exp_t e);
        drive(idx, 1'b1, addr);
        push(idx, e);
        @(posedge clk); #1;
        chk("busy_start", idx, 32'(busy_s[idx]), 32'd1);
        wait_resp(idx);
        drive(idx, 1'b0, 8'h00);
        @(posedge clk); #1;
    endtask

    task automatic b2b(input int idx, input logic [7:0] addr, input exp_t e, input int n);
        drive(idx, 1'b1, addr);
        push(idx, e);
        @(posedge clk); #1;
        for (int k = 0; k < n; k++) begin
            chk("b2b_start", idx, 32'(busy_s[idx]), 32'd1);
            wait_resp(idx);
            if (k == n - 1) drive(idx, 1'b0, 8'h00);
            else            push(idx, e);
            @(posedge clk); #1;
            chk("b2b_idle_gap", idx, 32'(busy_s[idx]), 32'd0);
            if (k < n - 1) begin
                @(posedge clk); #1;
            end
        end
    endtask

    exp_t mon_e;
    int   run       [3];
    logic prev_done [3];

    initial begin
        for (int i = 0; i < 3; i++) begin
            run[i]       = 0;
            prev_done[i] = 1'b0;
        end
        forever begin
            @(negedge clk);
            if (mon_en) begin
                for (int i = 0; i < 3; i++) begin
                    chk("onehot", i, 32'($onehot0(ce_s[i])), 32'd1);
                    chk("ack_err_excl", i, 32'(ack_s[i] && err_s[i]), 32'd0);
                    if (!busy_s[i])
                        chk("idle_quiet", i, 32'({ce_s[i], ack_s[i], err_s[i]}), 32'd0);
                    else if (!err_s[i])
                        chk("access_ce", i, 32'(ce_s[i] != 4'd0), 32'd1);
                    if (err_s[i]) chk("fault_ce", i, 32'(ce_s[i]), 32'd0);
                    if (prev_done[i]) chk("idle_after_resp", i, 32'(busy_s[i]), 32'd0);
                    run[i] = busy_s[i] ? run[i] + 1 : 0;
                    if (ack_s[i] || err_s[i]) begin
                        if (qsize(i) == 0) begin
                            chk("unexpected_resp", i, 32'd1, 32'd0);
                        end else begin
                            pop(i, mon_e);
                            chk("resp_ack", i, 32'(ack_s[i]), 32'(!mon_e.is_err));
                            chk("resp_err", i, 32'(err_s[i]), 32'(mon_e.is_err));
                            chk("resp_ce", i, 32'(ce_s[i]), 32'(mon_e.ce));
                            chk("resp_len", i, 32'(run[i]), 32'(mon_e.len));
                        end
                    end else if (busy_s[i] && qsize(i) > 0) begin
                        chk("hold_ce", i, 32'(ce_s[i]), 32'(front_ce(i)));
                    end
                    prev_done[i] = ack_s[i] || err_s[i];
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t      dummy;
        logic [7:0] a;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) drive(i, 1'b0, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        for (int c = 0; c < 10; c++) begin
            for (int i = 0; i < 3; i++)
                chk("reset_idle", i, 32'({ce_s[i], busy_s[i], ack_s[i], err_s[i]}), 32'd0);
            @(posedge clk); #1;
        end

        // N_CE=2, no wait states: mapped, unmapped and the decode boundary
        run_access(0, 8'h01, mk(1'b0, 4'b0010, 1));
        run_access(0, 8'h00, mk(1'b0, 4'b0001, 1));
        run_access(0, 8'h05, mk(1'b1, 4'b0000, 1));
        run_access(0, 8'h02, mk(1'b1, 4'b0000, 1));
        run_access(0, 8'hFF, mk(1'b1, 4'b0000, 1));
        b2b(0, 8'h05, mk(1'b1, 4'b0000, 1), 2);
        b2b(0, 8'h01, mk(1'b0, 4'b0010, 1), 2);

        // N_CE=4, three wait states, REQ held across accesses
        b2b(1, 8'h02, mk(1'b0, 4'b0100, 4), 3);
        run_access(1, 8'h03, mk(1'b0, 4'b1000, 4));
        run_access(1, 8'h04, mk(1'b1, 4'b0000, 1));

        // Reset in the 3rd CE cycle of a 6-cycle access; simultaneous REQ on idle dut0
        drive(2, 1'b1, 8'h01);
        push(2, mk(1'b0, 4'b0010, 6));
        @(posedge clk); #1;
        chk("busy_start", 2, 32'(busy_s[2]), 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("ce_before_rst", 2, 32'(ce_s[2]), 32'b0010);
        rst = 1'b1;
        pop(2, dummy);
        drive(0, 1'b1, 8'h00);
        @(posedge clk); #1;
        chk("rst_drops_access", 2, 32'({ce_s[2], busy_s[2], ack_s[2], err_s[2]}), 32'd0);
        chk("rst_beats_req", 0, 32'({ce_s[0], busy_s[0], ack_s[0], err_s[0]}), 32'd0);
        rst = 1'b0;
        drive(0, 1'b0, 8'h00);
        drive(2, 1'b0, 8'h00);
        @(posedge clk); #1;
        run_access(2, 8'h00, mk(1'b0, 4'b0001, 6));

        // Address sweep over all 256 values in a scrambled order
        for (int k = 0; k < 256; k++) begin
            a = 8'(k * 167);
            if (a == 8'h00)      run_access(0, a, mk(1'b0, 4'b0001, 1));
            else if (a == 8'h01) run_access(0, a, mk(1'b0, 4'b0010, 1));
            else                 run_access(0, a, mk(1'b1, 4'b0000, 1));
        end

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) chk("queue_drained", i, 32'(qsize(i)), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
